mux_stream_arb: RTL and testbench
=================================

# mux_stream_arb

Parametrised N-channel registered multiplexer with a valid/ready handshake on every input and on the output. It selects one channel per cycle, either by an explicit select code (fixed mode) or by round-robin arbitration, and holds the chosen word in a one-entry output register. It is the multi-channel, pipelined successor to the datapath's 2-to-1 operand mux. It sits between several producers (register file read ports, immediate path, memory read data) and a single consumer stage.

## Interface
- WIDTH, 8: data width per channel, in bits. Data is treated as signed.
- CHANNELS, 4: number of input channels. Legal range is 2..16.
- SEL_WIDTH, 2: width of the select and channel codes. Must satisfy 2^SEL_WIDTH >= CHANNELS.

- CLK  in  1  clock. All state updates occur on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MODE  in  1  0 = fixed select, 1 = round-robin.
- SELECT  in  SEL_WIDTH  channel index, used in fixed mode only.
- IN_DATA  in  CHANNELS*WIDTH  flattened inputs. Channel i occupies bits [i*WIDTH +: WIDTH].
- IN_VALID  in  CHANNELS  per-channel valid.
- IN_READY  out  CHANNELS  per-channel ready. At most one bit is high at a time.
- OUT_DATA  out  WIDTH  registered, signed output word.
- OUT_VALID  out  1  OUT_DATA holds an unconsumed word.
- OUT_READY  in  1  the consumer accepts OUT_DATA this cycle.
- OUT_CHANNEL  out  SEL_WIDTH  index of the channel that supplied OUT_DATA.

## Operation
- **Load enable.** load_en = !OUT_VALID || OUT_READY. The output register can take a new word whenever it is empty or is being drained in the same cycle.
- **Grant, fixed mode (MODE=0).**
  - grant = SELECT when SELECT < CHANNELS and IN_VALID[SELECT] = 1.
  - Otherwise there is no grant.
  - An out-of-range SELECT never grants and never raises IN_READY.
- **Grant, round-robin mode (MODE=1).**
  - Scan channels starting at (PTR+1) mod CHANNELS, in ascending order with wrap-around.
  - The first channel with IN_VALID set wins.
  - If no channel is valid, there is no grant.
- **IN_READY.** IN_READY[i] = load_en && grant valid && grant == i. It is combinational from IN_VALID, MODE, SELECT, PTR, OUT_VALID and OUT_READY.
- **Input transfer.** A transfer occurs on channel i when IN_VALID[i] && IN_READY[i]. On that edge:
  - OUT_DATA <= channel i data;
  - OUT_CHANNEL <= i;
  - OUT_VALID <= 1;
  - in round-robin mode only, PTR <= i.
- **Output drain only.** If OUT_READY=1 and there is no input transfer, OUT_VALID <= 0. OUT_DATA and OUT_CHANNEL keep their values.
- **Stall.** While OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_CHANNEL and OUT_VALID are held stable, and all IN_READY bits are 0.
- **PTR.** Internal round-robin pointer, SEL_WIDTH bits.
  - Reset value is CHANNELS-1, so the first round-robin scan starts at channel 0.
  - Fixed-mode transfers do not change PTR.
- **Mode changes.** A change of MODE or SELECT affects the grant in the same cycle. A word already in the output register is unaffected.

## Timing
- **Reset (RESET=0, asynchronous).** OUT_VALID=0, OUT_DATA=0, OUT_CHANNEL=0, PTR=CHANNELS-1. IN_READY is all zero while reset is asserted.
- **Reset mid-operation.** Any held, unconsumed word is discarded; no partial state survives.
- **Latency.** One cycle: a word accepted at edge n is visible on OUT_DATA after edge n.
- **Throughput.** One word per cycle while OUT_READY is held at 1. There are no bubbles.
- **Simultaneous drain and load.** When OUT_READY=1 and a new grant exists in the same cycle, the register is overwritten with the new word and OUT_VALID stays 1.
- **Wrap-around.** With PTR=CHANNELS-1, the scan order is 0, 1, …, CHANNELS-1. With PTR=k, channel k has the lowest priority.
- **Output timing.** OUT_DATA, OUT_VALID and OUT_CHANNEL come directly from flops; there is no combinational path from the inputs to these outputs.

## Test plan
Defaults are used throughout (WIDTH=8, CHANNELS=4).
- **Reset values.** Assert RESET=0 mid-stream while OUT_VALID=1 → immediately OUT_VALID=0, OUT_DATA=0, OUT_CHANNEL=0. After release in MODE=1 with all IN_VALID high → the first grant is channel 0.
- **Fixed select.** MODE=0, SELECT=2, ch2=-54 with valid, OUT_READY=1 → IN_READY=4'b0100. Next cycle OUT_DATA=-54 (8'hCA), OUT_CHANNEL=2.
- **Fixed select, invalid channel.** MODE=0, SELECT=1 with IN_VALID[1]=0, other channels valid → IN_READY=0 and OUT_VALID falls to 0 after the drain.
- **Round-robin fairness.** MODE=1, all four channels continuously valid with data 10, 20, 30, 40, OUT_READY=1 → OUT_DATA sequence is 10, 20, 30, 40, 10 on consecutive cycles.
- **Back-pressure.** Load 23, then hold OUT_READY=0 for 3 cycles → OUT_DATA stays 23, OUT_VALID=1, IN_READY=0 throughout. Raise OUT_READY → the next grant loads on the same edge the 23 is consumed.
- **Round-robin skip and wrap.** MODE=1, PTR=2, only ch1 and ch3 valid → ch3 is granted, then ch1 (wrap-around); PTR ends at 1.

Source files
------------

// File: rtl/mux_stream_arb.sv
// mux_stream_arb
//   N-channel registered stream multiplexer. Each cycle one input channel is
//   granted, either by an explicit select code (mode=0) or by round-robin
//   arbitration (mode=1). The granted word lands in a one-entry output
//   register that is handed to the consumer with a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   mode         0 = fixed select, 1 = round-robin
//   select       channel index used in fixed mode
//   in_data      flattened inputs, channel i at [i*WIDTH +: WIDTH]
//   in_valid     per-channel valid
//   in_ready     per-channel ready (one-hot or zero)
//   out_data     registered signed output word
//   out_valid    out_data holds an unconsumed word
//   out_ready    consumer takes out_data this cycle
//   out_channel  channel that supplied out_data

// Per-channel slice: raises ready when this channel holds the grant and the
// output register can load, and contributes its data to the AND-OR mux.
module mux_stream_arb_lane #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 2,
    parameter int IDX       = 0
) (
    input  logic                 load_en,
    input  logic                 gnt_vld,
    input  logic [SEL_WIDTH-1:0] gnt_idx,
    input  logic [WIDTH-1:0]     data,
    output logic                 ready,
    output logic [WIDTH-1:0]     data_masked
);
    assign ready       = load_en && gnt_vld && (gnt_idx == SEL_WIDTH'(IDX));
    assign data_masked = data & {WIDTH{ready}};
endmodule

module mux_stream_arb #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode,
    input  logic [SEL_WIDTH-1:0]       select,
    input  logic [CHANNELS*WIDTH-1:0]  in_data,
    input  logic [CHANNELS-1:0]        in_valid,
    output logic [CHANNELS-1:0]        in_ready,
    output logic signed [WIDTH-1:0]    out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SEL_WIDTH-1:0]       out_channel
);

    generate
        if (CHANNELS < 2 || CHANNELS > 16)
            $error("mux_stream_arb: CHANNELS must be in 2..16");
        if ((1 << SEL_WIDTH) < CHANNELS)
            $error("mux_stream_arb: SEL_WIDTH too narrow for CHANNELS");
    endgenerate

    typedef struct packed {
        logic                 vld;
        logic [SEL_WIDTH-1:0] idx;
    } gnt_t;

    logic [CHANNELS-1:0][WIDTH-1:0] ch_data;
    logic [CHANNELS-1:0][WIDTH-1:0] lane_data;
    logic [CHANNELS-1:0]            lane_ready;
    logic [SEL_WIDTH-1:0]           ptr;
    logic                           load_en;
    logic                           xfer;
    logic [WIDTH-1:0]               sel_data;
    gnt_t                           gnt_fix;
    gnt_t                           gnt_rr;
    gnt_t                           gnt;

    assign ch_data = in_data;
    assign load_en = !out_valid || out_ready;

    // Fixed mode: an out-of-range select matches no lane, so it never grants.
    always_comb begin
        gnt_fix = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (select == SEL_WIDTH'(i) && in_valid[i]) begin
                gnt_fix.vld = 1'b1;
                gnt_fix.idx = SEL_WIDTH'(i);
            end
        end
    end

    // Round-robin: scan from ptr+1 upward with wrap; the last winner (ptr)
    // is visited last. ptr < CHANNELS, so one conditional subtract is enough
    // for the wrap.
    always_comb begin
        int idx;
        gnt_rr = '0;
        idx    = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CHANNELS)
                idx = idx - CHANNELS;
            if (!gnt_rr.vld && in_valid[idx]) begin
                gnt_rr.vld = 1'b1;
                gnt_rr.idx = SEL_WIDTH'(idx);
            end
        end
    end

    assign gnt = mode ? gnt_rr : gnt_fix;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            mux_stream_arb_lane #(
                .WIDTH     (WIDTH),
                .SEL_WIDTH (SEL_WIDTH),
                .IDX       (gi)
            ) u_lane (
                .load_en     (load_en),
                .gnt_vld     (gnt.vld),
                .gnt_idx     (gnt.idx),
                .data        (ch_data[gi]),
                .ready       (lane_ready[gi]),
                .data_masked (lane_data[gi])
            );
        end
    endgenerate

    // Ready is forced low while reset is held, even though the empty output
    // register would otherwise allow a load.
    assign in_ready = lane_ready & {CHANNELS{rst_n}};

    // Ready is only raised on a valid lane, so any ready bit is a transfer.
    assign xfer = |in_ready;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++)
            sel_data = sel_data | lane_data[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_channel <= '0;
            out_valid   <= 1'b0;
            ptr         <= SEL_WIDTH'(CHANNELS - 1);
        end else if (xfer) begin
            out_data    <= sel_data;
            out_channel <= gnt.idx;
            out_valid   <= 1'b1;
            if (mode)
                ptr <= gnt.idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_stream_arb.sv
module tb_mux_stream_arb;

    localparam int WIDTH     = 8;
    localparam int CHANNELS  = 4;
    localparam int SEL_WIDTH = 2;

    typedef struct {
        logic [7:0] d;
        logic [1:0] ch;
    } exp_t;

    logic                       clk;
    logic                       rst_n;
    logic                       mode;
    logic [SEL_WIDTH-1:0]       select;
    logic [CHANNELS*WIDTH-1:0]  in_data;
    logic [CHANNELS-1:0]        in_valid;
    logic [CHANNELS-1:0]        in_ready;
    logic signed [WIDTH-1:0]    out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [SEL_WIDTH-1:0]       out_channel;

    int   checks;
    int   errors;
    exp_t sb[$];

    mux_stream_arb #(
        .WIDTH     (WIDTH),
        .CHANNELS  (CHANNELS),
        .SEL_WIDTH (SEL_WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .select      (select),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_channel (out_channel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] ch);
        exp_t e;
        e.d  = d;
        e.ch = ch;
        sb.push_back(e);
    endtask

    task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        in_data = {d, c, b, a};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word seen with valid and ready between edges is consumed at
    // the next rising edge, so each negedge observation is one handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h/ch%0d expected nothing", out_data, out_channel);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", 8'(out_data), e.d);
                chk("sb_chan", 8'(out_channel), 8'(e.ch));
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        mode      = 1'b1;
        select    = '0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        set_data(8'd10, 8'd20, 8'd30, 8'd40);

        // Reset values, ready held low during reset
        #2;
        chk("rst_valid", 8'(out_valid), 8'd0);
        chk("rst_data", 8'(out_data), 8'd0);
        chk("rst_chan", 8'(out_channel), 8'd0);
        chk("rst_ready", 8'(in_ready), 8'd0);

        // Round-robin fairness from reset: 10,20,30,40,10
        step();
        rst_n = 1'b1;
        #2;
        chk("rr_first", 8'(in_ready), 8'b0001);
        push(8'd10, 2'd0);
        push(8'd20, 2'd1);
        push(8'd30, 2'd2);
        push(8'd40, 2'd3);
        push(8'd10, 2'd0);
        repeat (5) @(posedge clk);
        #1;
        in_valid = 4'h0;
        step();
        chk("rr_drain", 8'(out_valid), 8'd0);

        // Fixed select ch2 = -54
        mode     = 1'b0;
        select   = 2'd2;
        set_data(8'd1, 8'd2, 8'hCA, 8'd4);
        in_valid = 4'hF;
        #2;
        chk("fix_ready", 8'(in_ready), 8'b0100);
        push(8'hCA, 2'd2);
        step();
        // Selected channel not valid, others valid: no grant
        select   = 2'd1;
        in_valid = 4'b1101;
        #2;
        chk("fix_invalid", 8'(in_ready), 8'd0);
        step();
        chk("fix_drain", 8'(out_valid), 8'd0);
        chk("fix_hold_data", 8'(out_data), 8'hCA);
        chk("fix_hold_chan", 8'(out_channel), 8'd2);

        // Back-pressure: load 23, stall 3 cycles, then drain+reload same edge
        select    = 2'd3;
        set_data(8'd1, 8'd55, 8'd3, 8'd23);
        in_valid  = 4'b1000;
        out_ready = 1'b0;
        #2;
        chk("bp_load_ready", 8'(in_ready), 8'b1000);
        push(8'd23, 2'd3);
        step();
        select   = 2'd1;
        in_valid = 4'b0010;
        repeat (3) begin
            #2;
            chk("bp_data", 8'(out_data), 8'd23);
            chk("bp_valid", 8'(out_valid), 8'd1);
            chk("bp_ready", 8'(in_ready), 8'd0);
            step();
        end
        out_ready = 1'b1;
        #2;
        chk("bp_release_ready", 8'(in_ready), 8'b0010);
        push(8'd55, 2'd1);
        step();
        in_valid = 4'h0;
        chk("bp_reload_valid", 8'(out_valid), 8'd1);
        chk("bp_reload_data", 8'(out_data), 8'd55);
        step();

        // Round-robin: fixed transfers left the pointer at 0
        mode     = 1'b1;
        set_data(8'd10, 8'd20, 8'd30, 8'd40);
        in_valid = 4'hF;
        #1;
        chk("rr_ptr_kept", 8'(in_ready), 8'b0010);
        in_valid = 4'b0100;
        #1;
        chk("rr_skip", 8'(in_ready), 8'b0100);
        push(8'd30, 2'd2);
        step();
        // ptr=2, ch1 and ch3 valid: ch3 then ch1 (wrap)
        in_valid = 4'b1010;
        #2;
        chk("rr_wrap_a", 8'(in_ready), 8'b1000);
        push(8'd40, 2'd3);
        step();
        #2;
        chk("rr_wrap_b", 8'(in_ready), 8'b0010);
        push(8'd20, 2'd1);
        step();
        // ptr=1 now: all valid grants ch2; this word is discarded by reset
        in_valid = 4'hF;
        #2;
        chk("rr_ptr_end", 8'(in_ready), 8'b0100);
        step();
        out_ready = 1'b0;
        #2;
        chk("mid_valid", 8'(out_valid), 8'd1);
        chk("mid_data", 8'(out_data), 8'd30);

        // Reset mid-stream discards the held word
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 8'(out_valid), 8'd0);
        chk("mid_rst_data", 8'(out_data), 8'd0);
        chk("mid_rst_chan", 8'(out_channel), 8'd0);
        chk("mid_rst_ready", 8'(in_ready), 8'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #2;
        chk("post_rst_first", 8'(in_ready), 8'b0001);
        push(8'd10, 2'd0);
        step();
        in_valid = 4'h0;

        begin
            int budget;
            budget = 20;
            while (sb.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #1;
            chk("sb_empty", 8'(sb.size()), 8'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
